// File: rtl/grf_wb_arbiter.sv
// rtl/grf_wb_arbiter.sv - GRF write-port arbiter: W-stage writeback vs buffered MDU results
module grf_wb_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_a3,
  input  logic [31:0] wb_wd,
  input  logic [31:0] wb_pc,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_a3,
  input  logic [31:0] md_wd,
  input  logic [31:0] md_pc,
  output logic        grf_we,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_pc,
  output logic        stall_wb,
  output logic [31:0] busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PEND  = 2'd1,
    S_FORCE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [FIFO_DEPTH-1:0] valid_q, killed_q;
  logic [4:0]      a3_q [FIFO_DEPTH];
  logic [31:0]     wd_q [FIFO_DEPTH];
  logic [31:0]     pc_q [FIFO_DEPTH];

  logic            full;
  logic            push;
  logic            pop;
  logic            wb_wr;
  logic            kill_en;
  logic [4:0]      head_a3;
  logic [31:0]     head_wd;
  logic [31:0]     head_pc;
  logic            head_killed;

  // md_ready deliberately ignores a same-cycle pop so the handshake never depends on arbitration.
  assign full        = (count_q == CW'(FIFO_DEPTH));
  assign md_ready    = !reset && !full;
  // Results for $0 are handshaken but never stored.
  assign push        = md_valid && md_ready && (md_a3 != 5'd0);
  assign head_a3     = a3_q[rd_ptr_q];
  assign head_wd     = wd_q[rd_ptr_q];
  assign head_pc     = pc_q[rd_ptr_q];
  assign head_killed = killed_q[rd_ptr_q];

  // Port arbitration and next-state: pipeline first, head drains on idle W cycles or when starved.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    pop      = 1'b0;
    stall_wb = 1'b0;
    wb_wr    = wb_we;
    grf_we   = wb_we;
    grf_a3   = wb_a3;
    grf_wd   = wb_wd;
    grf_pc   = wb_pc;
    case (state_q)
      S_PEND: begin
        if (head_killed) begin
          // A stale head needs no port, so it retires while the pipeline keeps writing.
          pop      = 1'b1;
          starve_d = '0;
        end else if (wb_we) begin
          starve_d = starve_q + SW'(1);
        end else begin
          pop      = 1'b1;
          starve_d = '0;
          grf_we   = 1'b1;
          grf_a3   = head_a3;
          grf_wd   = head_wd;
          grf_pc   = head_pc;
        end
      end
      S_FORCE: begin
        stall_wb = 1'b1;
        pop      = 1'b1;
        starve_d = '0;
        wb_wr    = 1'b0;
        grf_we   = !head_killed;
        grf_a3   = head_a3;
        grf_wd   = head_wd;
        grf_pc   = head_pc;
      end
      default: begin
      end
    endcase
    count_d = count_q + CW'(push) - CW'(pop);
    if ((state_q == S_PEND) && (starve_d == SW'(STARVE_LIMIT))) begin
      state_d = S_FORCE;
    end else if (count_d == '0) begin
      state_d = S_IDLE;
    end else begin
      state_d = S_PEND;
    end
    if (reset) begin
      state_d  = S_IDLE;
      starve_d = '0;
      count_d  = '0;
      pop      = 1'b0;
      stall_wb = 1'b0;
      wb_wr    = 1'b0;
      grf_we   = 1'b0;
      grf_a3   = 5'd0;
      grf_wd   = 32'd0;
      grf_pc   = 32'd0;
    end
  end

  // A pipeline write to $r makes every older queued result for $r stale.
  assign kill_en = wb_wr && (wb_a3 != 5'd0);

  // Control state, FIFO pointers and per-entry live/killed flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      starve_q <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      valid_q  <= '0;
      killed_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      count_q  <= count_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (kill_en && valid_q[i] && (a3_q[i] == wb_a3)) begin
          killed_q[i] <= 1'b1;
        end
      end
      if (pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PW'(1);
      end
      // The push slot is never live, so a same-cycle kill cannot touch the new entry.
      if (push) begin
        valid_q[wr_ptr_q]  <= 1'b1;
        killed_q[wr_ptr_q] <= 1'b0;
        wr_ptr_q           <= wr_ptr_q + PW'(1);
      end
    end
  end

  // Entry payload storage; needs no reset because live flags gate every use.
  always_ff @(posedge clk) begin
    if (push) begin
      a3_q[wr_ptr_q] <= md_a3;
      wd_q[wr_ptr_q] <= md_wd;
      pc_q[wr_ptr_q] <= md_pc;
    end
  end

  // Busy mask: destinations of live, non-killed queued results.
  always_comb begin
    busy = 32'd0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (valid_q[i] && !killed_q[i]) begin
        busy[a3_q[i]] = 1'b1;
      end
    end
    busy[0] = 1'b0;
    if (reset) begin
      busy = 32'd0;
    end
  end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// tb/tb_grf_wb_arbiter.sv - directed scoreboard bench for grf_wb_arbiter
module tb_grf_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_a3;
  logic [31:0] wb_wd;
  logic [31:0] wb_pc;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_a3;
  logic [31:0] md_wd;
  logic [31:0] md_pc;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;
  logic        stall_wb;
  logic [31:0] busy;

  typedef struct packed {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  always #5 clk = ~clk;

  grf_wb_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_a3(wb_a3), .wb_wd(wb_wd), .wb_pc(wb_pc),
    .md_valid(md_valid), .md_ready(md_ready), .md_a3(md_a3), .md_wd(md_wd), .md_pc(md_pc),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
    .stall_wb(stall_wb), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expw(input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
    wr_t e;
    e.a3 = a3;
    e.wd = wd;
    e.pc = pc;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Every GRF write must match the next expected write, in order.
  always @(negedge clk) begin
    if (grf_we !== 1'b0) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL wr_unexpected observed a3=%0d wd=%h pc=%h expected none", grf_a3, grf_wd, grf_pc);
      end
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        total++;
        assert ({grf_a3, grf_wd, grf_pc} === e) else begin
          bad++;
          $error("FAIL wr_data observed a3=%0d wd=%h pc=%h expected a3=%0d wd=%h pc=%h",
                 grf_a3, grf_wd, grf_pc, e.a3, e.wd, e.pc);
        end
      end
    end
  end

  initial begin
    // 1: reset with active requests
    reset = 1'b1;
    md_valid = 1'b1; md_a3 = 5'd7; md_wd = 32'h77; md_pc = 32'h0;
    wb_we = 1'b1; wb_a3 = 5'd3; wb_wd = 32'h33; wb_pc = 32'h0;
    for (int i = 0; i < 2; i++) begin
      mid();
      chk("rst_we", {31'd0, grf_we}, 32'd0);
      chk("rst_ready", {31'd0, md_ready}, 32'd0);
      chk("rst_busy", busy, 32'd0);
      chk("rst_stall", {31'd0, stall_wb}, 32'd0);
      chk("rst_wd", grf_wd, 32'd0);
      tick();
    end
    reset = 1'b0; md_valid = 1'b0; wb_we = 1'b0;

    // 2: MDU result through an idle port
    md_valid = 1'b1; md_a3 = 5'd8; md_wd = 32'h1234; md_pc = 32'h3000;
    mid();
    chk("t2_ready", {31'd0, md_ready}, 32'd1);
    chk("t2_busy_pre", busy, 32'd0);
    tick();
    md_valid = 1'b0;
    expw(5'd8, 32'h1234, 32'h3000);
    mid();
    chk("t2_busy", busy, 32'h100);
    tick();
    mid();
    chk("t2_busy_clr", busy, 32'd0);
    chk("t2_no_we", {31'd0, grf_we}, 32'd0);
    tick();

    // 3: starvation forces a one-cycle drain
    md_valid = 1'b1; md_a3 = 5'd9; md_wd = 32'h9999; md_pc = 32'h3004;
    tick();
    md_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wb_we = 1'b1; wb_a3 = 5'd3; wb_wd = 32'h300 + i; wb_pc = 32'h4000 + 4 * i;
      expw(5'd3, wb_wd, wb_pc);
      mid();
      chk("t3_stall_pre", {31'd0, stall_wb}, 32'd0);
      if (i == 4) chk("t3_busy", busy, 32'h200);
      tick();
    end
    wb_wd = 32'h305; wb_pc = 32'h4014;
    expw(5'd9, 32'h9999, 32'h3004);
    mid();
    chk("t3_force_stall", {31'd0, stall_wb}, 32'd1);
    chk("t3_force_a3", {27'd0, grf_a3}, 32'd9);
    tick();
    expw(5'd3, 32'h305, 32'h4014);
    mid();
    chk("t3_post_stall", {31'd0, stall_wb}, 32'd0);
    chk("t3_busy_clr", busy, 32'd0);
    tick();
    wb_we = 1'b0;

    // 4: pipeline write kills an older queued result for the same register
    md_valid = 1'b1; md_a3 = 5'd5; md_wd = 32'hAAAA; md_pc = 32'h3008;
    tick();
    md_valid = 1'b0;
    wb_we = 1'b1; wb_a3 = 5'd5; wb_wd = 32'hBBBB; wb_pc = 32'h4100;
    expw(5'd5, 32'hBBBB, 32'h4100);
    mid();
    chk("t4_busy", busy, 32'h20);
    tick();
    wb_we = 1'b0;
    mid();
    chk("t4_busy_clr", busy, 32'd0);
    chk("t4_no_we", {31'd0, grf_we}, 32'd0);
    tick();
    mid();
    chk("t4_ready", {31'd0, md_ready}, 32'd1);
    tick();

    // 5: full FIFO under continuous writeback
    for (int i = 0; i < 5; i++) begin
      wb_we = 1'b1; wb_a3 = 5'd2; wb_wd = 32'h200 + i; wb_pc = 32'h5000 + 4 * i;
      expw(5'd2, wb_wd, wb_pc);
      if (i < 3) begin
        md_valid = 1'b1; md_a3 = 5'd10 + 5'(i); md_wd = 32'hA0 + i; md_pc = 32'h3010 + 4 * i;
      end
      mid();
      if (i < 2) chk("t5_ready", {31'd0, md_ready}, 32'd1);
      if (i == 2) chk("t5_full", {31'd0, md_ready}, 32'd0);
      if (i == 3) chk("t5_busy", busy, 32'h0C00);
      tick();
    end
    wb_wd = 32'h205; wb_pc = 32'h5014;
    expw(5'd10, 32'hA0, 32'h3010);
    mid();
    chk("t5_force", {31'd0, stall_wb}, 32'd1);
    chk("t5_full_force", {31'd0, md_ready}, 32'd0);
    tick();
    expw(5'd2, 32'h205, 32'h5014);
    mid();
    chk("t5_ready_after", {31'd0, md_ready}, 32'd1);
    chk("t5_stall_after", {31'd0, stall_wb}, 32'd0);
    tick();
    wb_we = 1'b0; md_valid = 1'b0;
    expw(5'd11, 32'hA1, 32'h3014);
    mid();
    chk("t5_busy2", busy, 32'h1800);
    tick();
    expw(5'd12, 32'hA2, 32'h3018);
    mid();
    tick();
    mid();
    chk("t5_busy_clr", busy, 32'd0);
    tick();

    // 6: $0 destination is accepted and dropped
    md_valid = 1'b1; md_a3 = 5'd0; md_wd = 32'hDEAD; md_pc = 32'h301C;
    mid();
    chk("t6_ready", {31'd0, md_ready}, 32'd1);
    tick();
    md_valid = 1'b0;
    mid();
    chk("t6_busy", busy, 32'd0);
    chk("t6_no_we", {31'd0, grf_we}, 32'd0);
    tick();
    mid();
    chk("t6_no_we2", {31'd0, grf_we}, 32'd0);
    tick();

    // 7: reset while an entry is pending
    md_valid = 1'b1; md_a3 = 5'd13; md_wd = 32'hD0; md_pc = 32'h3020;
    tick();
    md_valid = 1'b0;
    wb_we = 1'b1; wb_a3 = 5'd4; wb_wd = 32'h400; wb_pc = 32'h6000;
    expw(5'd4, 32'h400, 32'h6000);
    mid();
    chk("t7_busy", busy, 32'h2000);
    tick();
    reset = 1'b1;
    mid();
    chk("t7_rst_we", {31'd0, grf_we}, 32'd0);
    chk("t7_rst_busy", busy, 32'd0);
    chk("t7_rst_ready", {31'd0, md_ready}, 32'd0);
    tick();
    reset = 1'b0; wb_we = 1'b0;
    mid();
    chk("t7_busy_lost", busy, 32'd0);
    chk("t7_no_we", {31'd0, grf_we}, 32'd0);
    tick();

    // 8: reset during the forced drain cycle
    md_valid = 1'b1; md_a3 = 5'd14; md_wd = 32'hE0; md_pc = 32'h3024;
    tick();
    md_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wb_we = 1'b1; wb_a3 = 5'd6; wb_wd = 32'h600 + i; wb_pc = 32'h7000 + 4 * i;
      expw(5'd6, wb_wd, wb_pc);
      tick();
    end
    reset = 1'b1;
    mid();
    chk("t8_rst_stall", {31'd0, stall_wb}, 32'd0);
    chk("t8_rst_we", {31'd0, grf_we}, 32'd0);
    tick();
    reset = 1'b0; wb_we = 1'b0;
    mid();
    chk("t8_busy", busy, 32'd0);
    chk("t8_stall", {31'd0, stall_wb}, 32'd0);
    chk("t8_no_we", {31'd0, grf_we}, 32'd0);
    tick();
    mid();
    chk("t8_no_we2", {31'd0, grf_we}, 32'd0);
    tick();

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
